// File: rtl/sync_debounce.sv
// Multi-channel input conditioner for keypad and switch pins.
// Each channel is synchronized, then debounced, then edge-detected into registered pulses.
module sync_debounce #(
  parameter int WIDTH     = 4,
  parameter int STAGES    = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_active
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [STAGES-1:0][WIDTH-1:0] stage;
  logic [CNT_W-1:0]             cnt [WIDTH];

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage[0] <= async_in;
      for (int k = 1; k < STAGES; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign sync_out = stage[STAGES-1];

  // A new level is accepted only after DB_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (sync_out[i] != stable[i]) begin
          if (cnt[i] == CNT_MAX) begin
            stable[i] <= sync_out[i];
            rise[i]   <= sync_out[i];
            fall[i]   <= ~sync_out[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign any_active = |stable;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce with STAGES=2, DB_CYCLES=4, plus a DB_CYCLES=1 instance.
// Inputs change 3 time units after a rising edge; outputs are sampled 1 unit after it.
module tb_sync_debounce;

  logic       clk;
  logic       reset;
  logic [3:0] async_in;
  logic [3:0] sync_out, stable, rise, fall;
  logic       any_active;
  logic [3:0] sync_out1, stable1, rise1, fall1;
  logic       any_active1;

  int checks = 0;
  int errors = 0;

  sync_debounce #(.WIDTH(4), .STAGES(2), .DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .async_in(async_in),
    .sync_out(sync_out), .stable(stable), .rise(rise), .fall(fall),
    .any_active(any_active)
  );

  sync_debounce #(.WIDTH(4), .STAGES(2), .DB_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .async_in(async_in),
    .sync_out(sync_out1), .stable(stable1), .rise(rise1), .fall(fall1),
    .any_active(any_active1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    async_in = 4'b1111;

    // Reset values and post-reset rise of inputs already high
    for (int e = 1; e <= 2; e++) begin
      tick();
      check("rst_sync", sync_out, 0);
      check("rst_stable", stable, 0);
      check("rst_rise", rise, 0);
      check("rst_fall", fall, 0);
      check("rst_any", any_active, 0);
    end
    #2 reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("s1_sync", sync_out, (e >= 2) ? 4'b1111 : 4'b0000);
      check("s1_stable", stable, (e >= 6) ? 4'b1111 : 4'b0000);
      check("s1_rise", rise, (e == 6) ? 4'b1111 : 4'b0000);
      check("s1_any", any_active, (e >= 6) ? 1 : 0);
    end

    // Clean transition, with the DB_CYCLES=1 instance alongside
    #2 async_in = 4'b0000; reset = 1'b1;
    tick();
    check("s2_rst_stable", stable, 0);
    check("s2_rst_fall", fall, 0);
    #2 reset = 1'b0; async_in = 4'b1010;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("s2_sync", sync_out, (e >= 2) ? 4'b1010 : 4'b0000);
      check("s2_stable", stable, (e >= 6) ? 4'b1010 : 4'b0000);
      check("s2_rise", rise, (e == 6) ? 4'b1010 : 4'b0000);
      check("s2_fall", fall, 0);
      check("db1_sync", sync_out1, (e >= 2) ? 4'b1010 : 4'b0000);
      check("db1_stable", stable1, (e >= 3) ? 4'b1010 : 4'b0000);
      check("db1_rise", rise1, (e == 3) ? 4'b1010 : 4'b0000);
    end

    // Glitch rejection: three-cycle pulse on channel 0
    #2 async_in = 4'b1011;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check("s3_sync0", sync_out[0], (e >= 2 && e <= 4) ? 1 : 0);
      check("s3_stable", stable, 4'b1010);
      check("s3_rise", rise, 0);
      if (e == 3) #2 async_in = 4'b1010;
    end

    // Release
    #2 async_in = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("s4_fall", fall, (e == 6) ? 4'b1010 : 4'b0000);
      check("s4_stable", stable, (e >= 6) ? 4'b0000 : 4'b1010);
      check("s4_any", any_active, (e >= 6) ? 0 : 1);
      check("s4_rise", rise, 0);
    end

    // Reset mid-debounce loses the count
    #2 async_in = 4'b1000;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("s5_pre_stable", stable, 0);
    end
    #2 reset = 1'b1;
    tick();
    check("s5_rst_stable", stable, 0);
    check("s5_rst_sync", sync_out, 0);
    check("s5_rst_rise", rise, 0);
    #2 reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("s5_sync", sync_out, (e >= 2) ? 4'b1000 : 4'b0000);
      check("s5_stable", stable, (e == 6) ? 4'b1000 : 4'b0000);
      check("s5_rise", rise, (e == 6) ? 4'b1000 : 4'b0000);
    end

    // Independent channels: ch1 at edge 0, ch2 at edge 2
    #2 async_in = 4'b1010;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check("s6_rise", rise, (e == 6) ? 4'b0010 : (e == 8) ? 4'b0100 : 4'b0000);
      check("s6_stable", stable, (e < 6) ? 4'b1000 : (e < 8) ? 4'b1010 : 4'b1110);
      check("s6_fall", fall, 0);
      if (e == 2) #2 async_in = 4'b1110;
    end

    // Reset on the edge a flip would occur: reset wins, no pulse
    #2 async_in = 4'b1111;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("s7_stable", stable, 4'b1110);
      check("s7_rise", rise, 0);
    end
    #2 reset = 1'b1;
    tick();
    check("s7_rst_stable", stable, 0);
    check("s7_rst_rise", rise, 0);
    check("s7_rst_fall", fall, 0);
    check("s7_rst_any", any_active, 0);
    #2 reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
